fnd_scan_counter: RTL and testbench

FND_SCAN_COUNTER -- requirements
Module: fnd_scan_counter

---
 rtl/fnd_scan_counter.sv | 124 ++++++++++++
 tb/tb_fnd_scan_counter.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/fnd_scan_counter.sv
// fnd_scan_counter: BCD up/down counter with a multiplexed, active-low 7-segment scan driver.
// Define FND_ZERO_BLANK_EN to blank leading-zero digits on the display (o_count is unaffected).
module fnd_scan_counter #(
  parameter int DIGITS   = 4,
  parameter int TICK_DIV = 10_000_000,
  parameter int SCAN_DIV = 100_000
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_run,
  input  logic                  i_clear,
  input  logic                  i_down,
  output logic [4*DIGITS-1:0]   o_count,
  output logic                  o_wrap,
  output logic [DIGITS-1:0]     o_fndDigit,
  output logic [7:0]            o_fndData
);
  localparam int TW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
  localparam int SW = $clog2(SCAN_DIV);
  localparam int DW = DIGITS > 1 ? $clog2(DIGITS) : 1;
  localparam logic [TW-1:0] TICK_MAX = TW'(TICK_DIV - 1);
  localparam logic [SW-1:0] SCAN_MAX = SW'(SCAN_DIV - 1);
  localparam logic [DW-1:0] DIG_MAX  = DW'(DIGITS - 1);

  function automatic logic [7:0] seg(input logic [3:0] d);
    case (d)
      4'd0: seg = 8'hC0;
      4'd1: seg = 8'hF9;
      4'd2: seg = 8'hA4;
      4'd3: seg = 8'hB0;
      4'd4: seg = 8'h99;
      4'd5: seg = 8'h92;
      4'd6: seg = 8'h82;
      4'd7: seg = 8'hF8;
      4'd8: seg = 8'h80;
      4'd9: seg = 8'h90;
      default: seg = 8'hFF;
    endcase
  endfunction

  logic [TW-1:0]         tick_q, tick_d;
  logic [4*DIGITS-1:0]   count_q, count_d, step;
  logic                  wrap_q, wrap_d;
  logic                  tick, all_nine, all_zero;
  logic [SW-1:0]         scan_q, scan_d;
  logic [DW-1:0]         idx_q, idx_d;
  logic [DIGITS-1:0]     dig_q, dig_d;
  logic [7:0]            data_q, data_d;
  logic                  scan_step, blank;
  logic [3:0]            cur;

  assign tick = i_run && tick_q == TICK_MAX;

  // Ripple the decade carry/borrow from digit 0 upward.
  always_comb begin
    logic       c;
    logic [3:0] d;
    step     = count_q;
    c        = 1'b1;
    all_nine = 1'b1;
    all_zero = 1'b1;
    for (int k = 0; k < DIGITS; k++) begin
      d        = count_q[4*k +: 4];
      all_nine = all_nine && d == 4'd9;
      all_zero = all_zero && d == 4'd0;
      if (c) step[4*k +: 4] = i_down ? (d == 4'd0 ? 4'd9 : d - 4'd1) : (d == 4'd9 ? 4'd0 : d + 4'd1);
      c = c && (i_down ? d == 4'd0 : d == 4'd9);
    end
  end

  assign tick_d  = i_clear ? '0 : !i_run ? tick_q : tick ? '0 : tick_q + 1'b1;
  assign count_d = i_clear ? '0 : tick ? step : count_q;
  assign wrap_d  = !i_clear && tick && (i_down ? all_zero : all_nine);

  assign scan_step = scan_q == SCAN_MAX;
  assign scan_d    = scan_step ? '0 : scan_q + 1'b1;
  assign idx_d     = scan_step ? (idx_q == DIG_MAX ? '0 : idx_q + 1'b1) : idx_q;

  always_comb begin
    logic lead;
    cur   = 4'd0;
    blank = 1'b0;
    lead  = 1'b1;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      lead = lead && count_q[4*k +: 4] == 4'd0;
      if (idx_q == DW'(k)) begin
        cur = count_q[4*k +: 4];
`ifdef FND_ZERO_BLANK_EN
        blank = k != 0 && lead;
`else
        blank = 1'b0;
`endif
      end
    end
  end

  assign dig_d  = scan_step ? ~(DIGITS'(1) << idx_q) : dig_q;
  assign data_d = scan_step ? (blank ? 8'hFF : seg(cur)) : data_q;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      tick_q  <= '0;
      count_q <= '0;
      wrap_q  <= 1'b0;
      scan_q  <= '0;
      idx_q   <= '0;
      dig_q   <= '1;
      data_q  <= 8'hFF;
    end else begin
      tick_q  <= tick_d;
      count_q <= count_d;
      wrap_q  <= wrap_d;
      scan_q  <= scan_d;
      idx_q   <= idx_d;
      dig_q   <= dig_d;
      data_q  <= data_d;
    end
  end

  assign o_count    = count_q;
  assign o_wrap     = wrap_q;
  assign o_fndDigit = dig_q;
  assign o_fndData  = data_q;
endmodule

// File: tb/tb_fnd_scan_counter.sv
// tb_fnd_scan_counter: randomized scoreboard bench for fnd_scan_counter against an arithmetic reference model.
module tb_fnd_scan_counter;
  localparam int D = 2, T = 4, S = 3;
  localparam int MAXC = 99;
`ifdef FND_ZERO_BLANK_EN
  localparam bit BLANK = 1'b1;
`else
  localparam bit BLANK = 1'b0;
`endif

  typedef struct {
    logic [4*D-1:0] cnt;
    logic           wrap;
    logic [D-1:0]   dig;
    logic [7:0]     data;
  } exp_t;

  logic clk = 1'b0, rst_n, run, clr, down;
  logic [4*D-1:0] cnt;
  logic wrap;
  logic [D-1:0] dig;
  logic [7:0] data;
  logic rst2_n, run2;
  logic [15:0] cnt2;
  logic wrap2;
  logic [3:0] dig2;
  logic [7:0] data2;

  always #5 clk = ~clk;

  fnd_scan_counter #(.DIGITS(D), .TICK_DIV(T), .SCAN_DIV(S)) u_dut (
    .i_clk(clk), .i_reset(rst_n), .i_run(run), .i_clear(clr), .i_down(down),
    .o_count(cnt), .o_wrap(wrap), .o_fndDigit(dig), .o_fndData(data));

  fnd_scan_counter #(.DIGITS(4), .TICK_DIV(1), .SCAN_DIV(2)) u_b (
    .i_clk(clk), .i_reset(rst2_n), .i_run(run2), .i_clear(1'b0), .i_down(1'b0),
    .o_count(cnt2), .o_wrap(wrap2), .o_fndDigit(dig2), .o_fndData(data2));

  logic [7:0] seg_tab [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

  int total = 0, bad = 0;
  exp_t sb[$];
  int m_count, m_pre, m_n;
  logic m_wrap;
  logic [D-1:0] m_dig;
  logic [7:0] m_data;
  bit seen_carry, seen_upwrap, seen_borrow, seen_downwrap;

  function automatic int pow10(int e);
    int r = 1;
    for (int i = 0; i < e; i++) r *= 10;
    return r;
  endfunction

  function automatic logic [4*D-1:0] to_bcd(int v);
    logic [4*D-1:0] r;
    for (int k = 0; k < D; k++) begin
      r[4*k +: 4] = 4'(v % 10);
      v /= 10;
    end
    return r;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      if (bad <= 40) $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: count as an integer, display position derived from cycles since reset.
  always @(posedge clk) begin
    if (!rst_n) begin
      m_count = 0; m_pre = 0; m_n = 0; m_wrap = 0; m_dig = '1; m_data = 8'hFF;
    end else begin
      m_n++;
      if (m_n % S == 0) begin
        int idx;
        idx = (m_n / S - 1) % D;
        m_dig = '1;
        m_dig[idx] = 1'b0;
        m_data = seg_tab[(m_count / pow10(idx)) % 10];
        if (BLANK && idx > 0 && m_count / pow10(idx) == 0) m_data = 8'hFF;
      end
      m_wrap = 0;
      if (clr) begin
        m_count = 0; m_pre = 0;
      end else if (run) begin
        if (m_pre == T - 1) begin
          m_pre = 0;
          if (down) begin
            m_wrap = m_count == 0;
            m_count = m_count == 0 ? MAXC : m_count - 1;
          end else begin
            m_wrap = m_count == MAXC;
            m_count = m_count == MAXC ? 0 : m_count + 1;
          end
        end else m_pre++;
      end
    end
    sb.push_back('{to_bcd(m_count), m_wrap, m_dig, m_data});
  end

  logic [4*D-1:0] prev_cnt = '0;
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk("count", 32'(cnt), 32'(e.cnt));
      chk("wrap", 32'(wrap), 32'(e.wrap));
      chk("fnd_digit", 32'(dig), 32'(e.dig));
      chk("fnd_data", 32'(data), 32'(e.data));
    end
    if (prev_cnt == 8'h09 && cnt == 8'h10) seen_carry = 1;
    if (prev_cnt == 8'h99 && cnt == 8'h00 && wrap) seen_upwrap = 1;
    if (prev_cnt == 8'h10 && cnt == 8'h09) seen_borrow = 1;
    if (prev_cnt == 8'h00 && cnt == 8'h99 && wrap) seen_downwrap = 1;
    prev_cnt = cnt;
  end

  task automatic chk_reset_vals(string tag);
    chk({tag, "_count"}, 32'(cnt), 0);
    chk({tag, "_wrap"}, 32'(wrap), 0);
    chk({tag, "_digit"}, 32'(dig), 32'(2'b11));
    chk({tag, "_data"}, 32'(data), 32'hFF);
  endtask

  task automatic wait_count(int target, int budget, string name);
    int i;
    for (i = 0; i < budget && m_count != target; i++) @(negedge clk);
    chk(name, 32'(m_count), 32'(target));
  endtask

  task automatic wait_dig2(logic [3:0] want, string name);
    int i;
    for (i = 0; i < 20 && dig2 !== want; i++) @(negedge clk);
    chk(name, 32'(dig2), 32'(want));
  endtask

  initial begin
    logic [4*D-1:0] held;
    int i;
    rst_n = 0; run = 0; clr = 0; down = 0; rst2_n = 0; run2 = 0;
    repeat (3) @(negedge clk);
    chk_reset_vals("reset");
    rst_n = 1; rst2_n = 1;
    for (int e = 1; e <= 9; e++) begin
      @(negedge clk);
      if (e <= 2) chk("scan_pre", 32'(dig), 32'(2'b11));
      if (e == 3 || e == 9) chk("scan_d0", 32'(dig), 32'(2'b10));
      if (e == 6) chk("scan_d1", 32'(dig), 32'(2'b01));
    end
    run = 1; down = 0;
    repeat (400) @(negedge clk);
    down = 1;
    repeat (400) @(negedge clk);
    run = 0;
    held = to_bcd(m_count);
    repeat (20) @(negedge clk);
    chk("hold", 32'(cnt), 32'(held));
    run = 1; down = 0;
    for (i = 0; i < 1000 && !(m_count == MAXC && m_pre == T - 1); i++) @(negedge clk);
    chk("collide_setup", 32'(m_count == MAXC && m_pre == T - 1), 1);
    clr = 1;
    @(negedge clk);
    clr = 0;
    chk("clear_count", 32'(cnt), 0);
    chk("clear_wrap", 32'(wrap), 0);
    repeat (T - 1) @(negedge clk);
    chk("restart_hold", 32'(cnt), 0);
    @(negedge clk);
    chk("restart_step", 32'(cnt), 32'h01);
    wait_count(37, 1000, "reach_37");
    run = 0;
    repeat (8) @(negedge clk);
    for (i = 0; i < 10 && dig !== 2'b10; i++) @(negedge clk);
    chk("seg_7", 32'(data), 32'hF8);
    for (i = 0; i < 10 && dig !== 2'b01; i++) @(negedge clk);
    chk("seg_3", 32'(data), 32'hB0);
    repeat (2000) begin
      @(negedge clk);
      run = $urandom % 10 != 0;
      clr = $urandom % 50 == 0;
      if ($urandom % 40 == 0) down = ~down;
    end
    @(negedge clk);
    clr = 0; run = 1; down = 0;
    wait_count(57, 1500, "reach_57");
    #2 rst_n = 0;
    #1 chk_reset_vals("async");
    repeat (2) @(negedge clk);
    rst_n = 1;
    repeat (50) @(negedge clk);
    wait_dig2(4'b1110, "b_zero_d0");
    chk("b_zero_seg", 32'(data2), 32'hC0);
    run2 = 1;
    for (i = 0; i < 100 && cnt2 !== 16'h0042; i++) @(negedge clk);
    run2 = 0;
    chk("b_count", 32'(cnt2), 32'h0042);
    repeat (10) @(negedge clk);
    wait_dig2(4'b1110, "b_d0");
    chk("b_seg0", 32'(data2), 32'hA4);
    wait_dig2(4'b1101, "b_d1");
    chk("b_seg1", 32'(data2), 32'h99);
    wait_dig2(4'b1011, "b_d2");
    chk("b_seg2", 32'(data2), BLANK ? 32'hFF : 32'hC0);
    wait_dig2(4'b0111, "b_d3");
    chk("b_seg3", 32'(data2), BLANK ? 32'hFF : 32'hC0);
    chk("seen_carry", 32'(seen_carry), 1);
    chk("seen_upwrap", 32'(seen_upwrap), 1);
    chk("seen_borrow", 32'(seen_borrow), 1);
    chk("seen_downwrap", 32'(seen_downwrap), 1);
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
